layer_sequencer: RTL

Sequencer that time-shares one four-input feedforward neuron datapath across a whole layer of `NUM_NEURONS` neurons. It does three things:
- latches a 4-element float32 input vector once per layer;
- for each neuron in turn, fetches that neuron's packed weight vector from a synchronous weight memory, issues it to the datapath and waits for the result;
- writes each result into an output buffer at the neuron's index.

It sits between the layer-level control (start/done) and the multiply/add/relu datapath. A watchdog counter aborts the layer if the datapath never answers.

---
 rtl/layer_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/layer_sequencer.sv
// Time-shares one four-input neuron datapath across a layer: fetches each
// neuron's weights, issues them with the latched inputs and buffers the result.
module layer_sequencer #(
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     x_in,
  output logic             busy,
  output logic             layer_done,
  output logic             error,
  output logic             w_rd_en,
  output logic [IDX_W-1:0] w_addr,
  input  logic [127:0]     w_rdata,
  output logic [127:0]     dp_x,
  output logic [127:0]     dp_w,
  output logic             dp_valid,
  input  logic [31:0]      dp_result,
  input  logic             dp_done,
  output logic             out_we,
  output logic [IDX_W-1:0] out_addr,
  output logic [31:0]      out_data
);

  // state   | meaning
  // IDLE    | waiting for start
  // FETCH   | weight read issued for current neuron
  // WAIT_W  | weight word returning, captured into dp_w
  // ISSUE   | dp_valid pulse to datapath, watchdog cleared
  // WAIT_DP | waiting for dp_done or watchdog expiry
  // WRITE   | result written to output buffer at neuron index
  // DONE    | layer_done pulse

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_W, ISSUE, WAIT_DP, WRITE, DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_expire;
  logic             last_neuron;

  // wd_cnt holds the count before this cycle's increment, so expiry is one short
  assign wd_expire   = (wd_cnt == WD_LAST);
  assign last_neuron = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    layer_done = 1'b0;
    w_rd_en    = 1'b0;
    dp_valid   = 1'b0;
    out_we     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        w_rd_en   = 1'b1;
        state_nxt = WAIT_W;
      end
      WAIT_W: state_nxt = ISSUE;
      ISSUE: begin
        dp_valid  = 1'b1;
        state_nxt = WAIT_DP;
      end
      WAIT_DP: begin
        if (dp_done) state_nxt = WRITE;
        else if (wd_expire) state_nxt = IDLE;
      end
      WRITE: begin
        out_we    = 1'b1;
        state_nxt = last_neuron ? DONE : FETCH;
      end
      DONE: begin
        layer_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign w_addr   = idx;
  assign out_addr = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      wd_cnt   <= '0;
      error    <= 1'b0;
      dp_x     <= '0;
      dp_w     <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dp_x  <= x_in;
            idx   <= '0;
            error <= 1'b0;
          end
        end
        WAIT_W: dp_w <= w_rdata;
        ISSUE:  wd_cnt <= '0;
        WAIT_DP: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (dp_done) out_data <= dp_result;
          else if (wd_expire) error <= 1'b1;
        end
        WRITE: begin
          if (!last_neuron) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
